tqvp_rejunity_vga_capture: RTL and testbench



---
 rtl/tqvp_rejunity_vga_capture_if.sv | 15 +
 rtl/tqvp_rejunity_vga_capture.sv | 177 +++++++++++++++++
 tb/tb_tqvp_rejunity_vga_capture.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/tqvp_rejunity_vga_capture_if.sv
// TinyQV register-port bundle for the VGA capture peripheral.
// The CPU side drives address/data/strobes; the peripheral returns read data and an always-ready ack.
interface tqvp_rejunity_vga_capture_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (output address, data_in, data_write_n, data_read_n,
                  input  data_out, data_ready);
  modport slave  (input  address, data_in, data_write_n, data_read_n,
                  output data_out, data_ready);
endinterface

// File: rtl/tqvp_rejunity_vga_capture.sv
// Locks to VGA sync, measures line/frame timing and captures 256 keyed pixels of one scanline.
// Pixel k lands H_BACK_PORCH+k clocks after hsync deasserts; reads are combinational, no backpressure.
module tqvp_rejunity_vga_capture #(
  parameter int H_BACK_PORCH    = 48,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        ui_in,
  tqvp_rejunity_vga_capture_if.slave        bus,
  output logic                              user_interrupt
);
  typedef enum logic [2:0] {IDLE, WAIT_VSYNC, COUNT_LINES, BACK_PORCH, CAPTURE} state_t;

  state_t       state, state_next;
  logic [7:0]   vq;
  logic         hs_prev, vs_prev;
  logic [255:0] line_buf;
  logic [5:0]   key_color;
  logic [9:0]   target_line, line_cnt, frame_lines, lcnt;
  logic [10:0]  h_period, hcnt;
  logic [7:0]   cnt;
  logic         irq_en, done, miss, trunc;
  logic         set_done, set_miss, set_trunc, cap_wr;

  logic hs_act, vs_act, hs_assert, hs_deassert, vs_assert, vs_deassert, pix;
  assign hs_act      = vq[7] ^ SYNC_ACTIVE_LOW;
  assign vs_act      = vq[3] ^ SYNC_ACTIVE_LOW;
  assign hs_assert   = hs_act & ~hs_prev;
  assign hs_deassert = ~hs_act & hs_prev;
  assign vs_assert   = vs_act & ~vs_prev;
  assign vs_deassert = ~vs_act & vs_prev;
  assign pix         = ({vq[6:4], vq[2:0]} == key_color);

  logic wr, arm, status_clr;
  assign wr         = (bus.data_write_n != 2'b11);
  assign arm        = wr && (bus.address == 6'h38) && bus.data_in[0];
  assign status_clr = wr && (bus.address == 6'h3C) && bus.data_in[0];

  logic unused_bits;
  assign unused_bits = ^{bus.data_read_n, bus.data_in[31:10]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    set_done   = 1'b0;
    set_miss   = 1'b0;
    set_trunc  = 1'b0;
    cap_wr     = 1'b0;
    case (state)
      WAIT_VSYNC:  if (vs_deassert) state_next = COUNT_LINES;
      COUNT_LINES: begin
        if (vs_assert) begin
          set_miss   = 1'b1;
          state_next = IDLE;
        end else if (hs_deassert && line_cnt == target_line) begin
          state_next = BACK_PORCH;
        end
      end
      BACK_PORCH, CAPTURE: begin
        // A new sync edge means the line ended early: keep what was captured.
        if (hs_assert || vs_assert) begin
          set_trunc  = 1'b1;
          set_done   = 1'b1;
          state_next = IDLE;
        end else if (state == BACK_PORCH) begin
          if (cnt == 8'(H_BACK_PORCH - 1)) state_next = CAPTURE;
        end else begin
          cap_wr = 1'b1;
          if (cnt == 8'd255) begin
            set_done   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: ;
    endcase
    if (arm) begin
      state_next = WAIT_VSYNC;
      set_done   = 1'b0;
      set_miss   = 1'b0;
      set_trunc  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vq          <= {SYNC_ACTIVE_LOW, 3'b000, SYNC_ACTIVE_LOW, 3'b000};
      hs_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      hcnt        <= '0;
      h_period    <= '0;
      lcnt        <= '0;
      frame_lines <= '0;
    end else begin
      vq      <= ui_in;
      hs_prev <= hs_act;
      vs_prev <= vs_act;
      if (hs_assert) begin
        h_period <= hcnt;
        hcnt     <= 11'd1;
      end else if (hcnt != 11'h7FF) begin
        hcnt <= hcnt + 11'd1;
      end
      // An hsync edge coinciding with vsync belongs to the new frame.
      if (vs_assert) begin
        frame_lines <= lcnt;
        lcnt        <= {9'd0, hs_assert};
      end else if (hs_assert && lcnt != 10'h3FF) begin
        lcnt <= lcnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_buf       <= '0;
      key_color      <= 6'b001011;
      target_line    <= '0;
      irq_en         <= 1'b0;
      done           <= 1'b0;
      miss           <= 1'b0;
      trunc          <= 1'b0;
      line_cnt       <= '0;
      cnt            <= '0;
      user_interrupt <= 1'b0;
    end else begin
      if (state == WAIT_VSYNC)                      line_cnt <= '0;
      else if (state == COUNT_LINES && hs_deassert) line_cnt <= line_cnt + 10'd1;

      if (state == COUNT_LINES)                              cnt <= 8'd1;
      else if (state == BACK_PORCH && state_next == CAPTURE) cnt <= '0;
      else                                                   cnt <= cnt + 8'd1;

      if (cap_wr) line_buf[cnt] <= pix;

      if (wr && bus.address == 6'h30) key_color   <= bus.data_in[5:0];
      if (wr && bus.address == 6'h34) target_line <= bus.data_in[9:0];
      if (wr && bus.address == 6'h38) irq_en      <= bus.data_in[1];

      if (arm) begin
        done  <= 1'b0;
        miss  <= 1'b0;
        trunc <= 1'b0;
      end else begin
        if (set_done)        done <= 1'b1;
        else if (status_clr) done <= 1'b0;
        if (set_miss)  miss  <= 1'b1;
        if (set_trunc) trunc <= 1'b1;
      end

      user_interrupt <= done & irq_en;
    end
  end

  assign bus.data_ready = 1'b1;

  always_comb begin
    bus.data_out = 32'h0;
    if (!bus.address[5]) begin
      bus.data_out = line_buf[{bus.address[4:2], 5'b00000} +: 32];
    end else begin
      case (bus.address[4:2])
        3'b011:  bus.data_out = {frame_lines, 5'b00000, h_period, 6'b000000};
        3'b100:  bus.data_out = {26'd0, key_color};
        3'b101:  bus.data_out = {22'd0, target_line};
        3'b110:  bus.data_out = {30'd0, irq_en, 1'b0};
        3'b111:  bus.data_out = {28'd0, trunc, miss, (state != IDLE), done};
        default: bus.data_out = 32'h0;
      endcase
    end
  end
endmodule

// File: tb/tb_tqvp_rejunity_vga_capture.sv
// Scoreboard bench for the VGA capture peripheral: synthetic VGA frames plus register reads.
module tb_tqvp_rejunity_vga_capture;
  localparam int NONE = 9999;
  localparam logic [7:0] IDLE_UI = 8'hA8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] ui_in;
  logic user_interrupt;

  tqvp_rejunity_vga_capture_if bus ();

  tqvp_rejunity_vga_capture dut (
    .clk            (clk),
    .rst            (rst),
    .ui_in          (ui_in),
    .bus            (bus),
    .user_interrupt (user_interrupt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sample_cyc = 0;
  int irq_cyc    = -1;
  logic irq_prev = 1'b0;
  logic [255:0] exp_buf;
  bit m_armed;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (user_interrupt && !irq_prev) irq_cyc = cyc;
    irq_prev = user_interrupt;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address      = a;
    bus.data_in      = d;
    bus.data_write_n = 2'b10;
    @(negedge clk);
    bus.data_write_n = 2'b11;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] got;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.address     = a;
    bus.data_read_n = 2'b10;
    #1 got = bus.data_out;
    bus.data_read_n = 2'b11;
    chk(tag, got, exp_q.pop_front());
  endtask

  task automatic check_buf(input string tag);
    for (int w = 0; w < 8; w++)
      rd_chk($sformatf("%s_w%0d", tag, w), 6'(w * 4), exp_buf[w*32 +: 32]);
  endtask

  // Line l-2 is the line index counted from the vsync deassert; pixel k sits hs_w+48+k clocks into it.
  task automatic run_frame(input int n_lines, input int len, input int hs_w, input int tail,
                           input int pat, input int mode, input int trunc_at, input int rst_at);
    for (int l = 0; l < n_lines; l++) begin
      int ll;
      int hw;
      ll = (l >= n_lines - tail) ? 800 : len;
      hw = (l >= n_lines - tail) ? 96 : hs_w;
      for (int c = 0; c < ll; c++) begin
        logic hs;
        logic vs;
        logic [5:0] col;
        int k;
        hs  = (c < hw);
        vs  = (l < 2);
        col = 6'h10;
        k   = c - hw - 48;
        if (l - 2 == pat) begin
          if (k >= 0 && k < 256) begin
            col = (mode == 1 || k % 3 == 0) ? 6'h0B : 6'h10;
            if (trunc_at >= 0 && k >= trunc_at && k < trunc_at + 10) hs = 1'b1;
            if (k == 255) sample_cyc = cyc + 1;
            if (m_armed && (trunc_at < 0 || k < trunc_at)) exp_buf[k] = (col == 6'h0B);
          end
          if (c == rst_at) begin
            rst     = 1'b1;
            exp_buf = '0;
            m_armed = 1'b0;
          end
          if (rst_at >= 0 && c == rst_at + 3) rst = 1'b0;
        end
        @(negedge clk);
        ui_in = {~hs, col[5:3], ~vs, col[2:0]};
      end
      if (l - 2 == pat) m_armed = 1'b0;
    end
  endtask

  initial begin
    int lat;
    bus.address      = 6'h0;
    bus.data_in      = 32'h0;
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b11;
    ui_in   = IDLE_UI;
    exp_buf = '0;
    m_armed = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    rd_chk("rst_key",    6'h30, 32'h0000000B);
    rd_chk("rst_tgt",    6'h34, 32'h0);
    rd_chk("rst_ctrl",   6'h38, 32'h0);
    rd_chk("rst_stat",   6'h3C, 32'h0);
    rd_chk("rst_timing", 6'h2C, 32'h0);
    rd_chk("rst_w0",     6'h00, 32'h0);
    chk("rst_irq",    {31'b0, user_interrupt}, 32'd0);
    chk("data_ready", {31'b0, bus.data_ready}, 32'd1);

    // Timing: 525 hsync edges per frame, last lines 800 clocks long.
    run_frame(525, 24, 8, 2, NONE, 0, -1, -1);
    run_frame(1, 24, 8, 0, NONE, 0, -1, -1);
    rd_chk("timing",   6'h2C, {10'd525, 5'd0, 11'd800, 6'd0});
    rd_chk("unmapped", 6'h24, 32'h0);

    // Keyed capture of line 10 with interrupt.
    wr(6'h30, 32'h0B);
    wr(6'h34, 32'd10);
    wr(6'h38, 32'h3);
    m_armed = 1'b1;
    rd_chk("ctrl_rd", 6'h38, 32'h2);
    rd_chk("busy",    6'h3C, 32'h2);
    irq_cyc = -1;
    run_frame(14, 420, 96, 0, 10, 0, -1, -1);
    check_buf("pat");
    rd_chk("pat_w0_lit", 6'h00, 32'h49249249);
    rd_chk("done",       6'h3C, 32'h1);
    chk("irq_on", {31'b0, user_interrupt}, 32'd1);
    lat = irq_cyc - sample_cyc;
    chk("irq_lat", {31'b0, (lat >= 2 && lat <= 3)}, 32'd1);
    wr(6'h3C, 32'h1);
    rd_chk("clr_stat", 6'h3C, 32'h0);
    @(negedge clk);
    chk("irq_off", {31'b0, user_interrupt}, 32'd0);

    // Target beyond the frame: miss on the next vsync.
    wr(6'h34, 32'd600);
    wr(6'h38, 32'h3);
    run_frame(525, 24, 8, 0, NONE, 0, -1, -1);
    rd_chk("miss_busy", 6'h3C, 32'h2);
    run_frame(1, 24, 8, 0, NONE, 0, -1, -1);
    rd_chk("miss_stat", 6'h3C, 32'h4);

    // All-ones preload, then a capture cut short after 100 pixels.
    wr(6'h34, 32'd10);
    wr(6'h38, 32'h3);
    m_armed = 1'b1;
    run_frame(14, 420, 96, 0, 10, 1, -1, -1);
    check_buf("ones");
    rd_chk("ones_stat", 6'h3C, 32'h1);
    wr(6'h38, 32'h3);
    m_armed = 1'b1;
    rd_chk("rearm_stat", 6'h3C, 32'h2);
    run_frame(14, 420, 96, 0, 10, 0, 100, -1);
    check_buf("trunc");
    rd_chk("trunc_stat", 6'h3C, 32'h9);

    // Reset in the middle of a capture, then a clean capture.
    wr(6'h38, 32'h3);
    m_armed = 1'b1;
    run_frame(14, 420, 96, 0, 10, 1, -1, 300);
    rd_chk("rst_busy", 6'h3C, 32'h0);
    check_buf("rstclr");
    rd_chk("rst_key2", 6'h30, 32'h0000000B);
    wr(6'h34, 32'd10);
    wr(6'h38, 32'h3);
    m_armed = 1'b1;
    run_frame(14, 420, 96, 0, 10, 0, -1, -1);
    check_buf("after_rst");
    rd_chk("after_rst_stat", 6'h3C, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
